puzzle_dealer: RTL and testbench

Sequencing controller for the 24-game puzzle table. On a deal request it pseudo-randomly picks a 4-bit table index and drives it to the solvable-set lookup. It avoids repeating the two most recent puzzles, latches the four returned numbers into card slots in a rotated order, and signals completion with a one-cycle pulse. It sits between the game FSM (requester) and the combinational solvable-set table.

---
 rtl/puzzle_dealer_if.sv | 30 +++
 rtl/puzzle_dealer.sv | 135 +++++++++++++
 tb/tb_puzzle_dealer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/puzzle_dealer_if.sv
// Bus between the game FSM / solvable-set table and the puzzle dealer.
interface puzzle_dealer_if;
  logic       deal_req;
  logic       seed_load;
  logic [7:0] seed;
  logic [3:0] set_index;
  logic [9:0] set_num1;
  logic [9:0] set_num2;
  logic [9:0] set_num3;
  logic [9:0] set_num4;
  logic [9:0] card0;
  logic [9:0] card1;
  logic [9:0] card2;
  logic [9:0] card3;
  logic       deal_valid;
  logic       busy;
  logic [7:0] round;

  // Requester side: game FSM plus the table it owns.
  modport master (
    output deal_req, seed_load, seed, set_num1, set_num2, set_num3, set_num4,
    input  set_index, card0, card1, card2, card3, deal_valid, busy, round
  );

  // Dealer side.
  modport slave (
    input  deal_req, seed_load, seed, set_num1, set_num2, set_num3, set_num4,
    output set_index, card0, card1, card2, card3, deal_valid, busy, round
  );
endinterface

// File: rtl/puzzle_dealer.sv
// Puzzle dealer: picks a pseudo-random table index avoiding the two most
// recent puzzles, waits one cycle for the table, then latches rotated cards.
module puzzle_dealer (
  input  logic            clk,
  input  logic            rst,
  puzzle_dealer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PICK, FETCH, LATCH} state_t;

  localparam logic [7:0] SEED_DEFAULT = 8'hA5;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] set_index_q, set_index_d;
  logic [1:0] rot_q, rot_d;
  logic [2:0] retry_q, retry_d;
  logic [3:0] h0_q, h0_d, h1_q, h1_d;
  logic       h0_v_q, h0_v_d, h1_v_q, h1_v_d;
  logic [9:0] card_q [4];
  logic [9:0] card_d [4];
  logic       deal_valid_q, deal_valid_d;
  logic       busy_q, busy_d;
  logic [7:0] round_q, round_d;

  logic [9:0] set_num [4];
  logic [3:0] cand;
  logic       hist_hit;

  assign set_num[0] = bus.set_num1;
  assign set_num[1] = bus.set_num2;
  assign set_num[2] = bus.set_num3;
  assign set_num[3] = bus.set_num4;

  // Candidate comes straight from the live LFSR; a hit means it repeats a recent puzzle.
  assign cand     = lfsr_q[3:0];
  assign hist_hit = (h0_v_q && (h0_q == cand)) || (h1_v_q && (h1_q == cand));

  // Next-state logic for the FSM, LFSR, history and outputs.
  always_comb begin
    state_d      = state_q;
    set_index_d  = set_index_q;
    rot_d        = rot_q;
    retry_d      = retry_q;
    h0_d         = h0_q;
    h1_d         = h1_q;
    h0_v_d       = h0_v_q;
    h1_v_d       = h1_v_q;
    round_d      = round_q;
    deal_valid_d = 1'b0;
    for (int k = 0; k < 4; k++) card_d[k] = card_q[k];

    // The LFSR runs freely in every state; a seed load overrides one step.
    if (bus.seed_load)
      lfsr_d = (bus.seed == 8'h00) ? SEED_DEFAULT : bus.seed;
    else
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      IDLE: begin
        if (bus.deal_req) state_d = PICK;
      end
      PICK: begin
        // After seven rejections the candidate is taken anyway to bound latency.
        if (!hist_hit || (retry_q == 3'd7)) begin
          set_index_d = cand;
          rot_d       = lfsr_q[5:4];
          retry_d     = 3'd0;
          state_d     = FETCH;
        end else begin
          retry_d = retry_q + 3'd1;
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        for (int k = 0; k < 4; k++) card_d[k] = set_num[2'(k) + rot_q];
        h1_d         = h0_q;
        h1_v_d       = h0_v_q;
        h0_d         = set_index_q;
        h0_v_d       = 1'b1;
        round_d      = (round_q == 8'hFF) ? round_q : round_q + 8'd1;
        deal_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state registers, with synchronous reset to the idle/cleared values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED_DEFAULT;
      set_index_q  <= 4'd0;
      rot_q        <= 2'd0;
      retry_q      <= 3'd0;
      h0_q         <= 4'd0;
      h1_q         <= 4'd0;
      h0_v_q       <= 1'b0;
      h1_v_q       <= 1'b0;
      deal_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      round_q      <= 8'd0;
      for (int k = 0; k < 4; k++) card_q[k] <= 10'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      set_index_q  <= set_index_d;
      rot_q        <= rot_d;
      retry_q      <= retry_d;
      h0_q         <= h0_d;
      h1_q         <= h1_d;
      h0_v_q       <= h0_v_d;
      h1_v_q       <= h1_v_d;
      deal_valid_q <= deal_valid_d;
      busy_q       <= busy_d;
      round_q      <= round_d;
      for (int k = 0; k < 4; k++) card_q[k] <= card_d[k];
    end
  end

  assign bus.set_index  = set_index_q;
  assign bus.card0      = card_q[0];
  assign bus.card1      = card_q[1];
  assign bus.card2      = card_q[2];
  assign bus.card3      = card_q[3];
  assign bus.deal_valid = deal_valid_q;
  assign bus.busy       = busy_q;
  assign bus.round      = round_q;

endmodule

// File: tb/tb_puzzle_dealer.sv
// Bench for puzzle_dealer: randomized deals checked cycle by cycle against a
// behavioural model (free-running LFSR, history queue, table lookup).
module tb_puzzle_dealer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puzzle_dealer_if bus ();

  puzzle_dealer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int forced   = 0;
  int m_round  = 0;
  int n_deals  = 0;
  int hist[$];
  logic [7:0] m_l;

  // Table model: entry idx holds idx+2..idx+5; indices 14 and 15 share one entry.
  function automatic logic [9:0] tbl_num(input logic [3:0] idx, input int k);
    if (idx >= 4'd14) return (k < 2) ? 10'd3 : 10'd8;
    return 10'(idx) + 10'(2 + k);
  endfunction

  always_comb begin
    bus.set_num1 = tbl_num(bus.set_index, 0);
    bus.set_num2 = tbl_num(bus.set_index, 1);
    bus.set_num3 = tbl_num(bus.set_index, 2);
    bus.set_num4 = tbl_num(bus.set_index, 3);
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Reference LFSR, stepped at every rising edge.
  always @(posedge clk) begin
    if (rst)                m_l <= 8'hA5;
    else if (bus.seed_load) m_l <= (bus.seed == 8'h00) ? 8'hA5 : bus.seed;
    else                    m_l <= lfsr_step(m_l);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_idx"},   32'(bus.set_index), 32'd0);
    check({tag, "_c0"},    32'(bus.card0), 32'd0);
    check({tag, "_c1"},    32'(bus.card1), 32'd0);
    check({tag, "_c2"},    32'(bus.card2), 32'd0);
    check({tag, "_c3"},    32'(bus.card3), 32'd0);
    check({tag, "_dv"},    32'(bus.deal_valid), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_round"}, 32'(bus.round), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.deal_req = 1'b0;
    bus.seed_load = 1'b0;
    @(negedge clk);
    check_cleared("rst");
    rst = 1'b0;
    hist.delete();
    m_round = 0;
  endtask

  // One deal. first: raise deal_req here (otherwise it is already high from the
  // previous deal). keep: leave deal_req high for a chained next deal.
  task automatic do_deal(input bit first, input bit keep, input bit poke_fetch, input bit abort);
    int retry;
    bit hit;
    bit done;
    logic [3:0] cand;
    logic [1:0] rot;
    logic [9:0] exp_card [4];
    if (first) begin
      @(negedge clk);
      bus.deal_req = 1'b1;
    end
    @(negedge clk);
    bus.deal_req  = keep;
    bus.seed_load = 1'b0;
    retry = 0;
    done  = 1'b0;
    cand  = 4'd0;
    rot   = 2'd0;
    while (!done) begin
      check("pick_busy", 32'(bus.busy), 32'd1);
      check("pick_dv",   32'(bus.deal_valid), 32'd0);
      cand = m_l[3:0];
      hit  = 1'b0;
      foreach (hist[i]) if (hist[i] == int'(cand)) hit = 1'b1;
      if (!hit || retry == 7) begin
        done = 1'b1;
        if (hit) forced++;
        rot = m_l[5:4];
      end else begin
        retry++;
      end
      @(negedge clk);
    end
    check("fetch_idx",  32'(bus.set_index), 32'(cand));
    check("fetch_busy", 32'(bus.busy), 32'd1);
    if (poke_fetch) bus.deal_req = 1'b1;
    @(negedge clk);
    if (poke_fetch) bus.deal_req = 1'b0;
    check("latch_idx",  32'(bus.set_index), 32'(cand));
    check("latch_busy", 32'(bus.busy), 32'd1);
    check("latch_dv",   32'(bus.deal_valid), 32'd0);
    if (abort) begin
      rst = 1'b1;
      @(negedge clk);
      check_cleared("abort");
      rst = 1'b0;
      hist.delete();
      m_round = 0;
      $display("deal aborted by reset idx=%0d", cand);
      return;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) exp_card[k] = tbl_num(cand, (k + int'(rot)) % 4);
    if (m_round < 255) m_round++;
    hist.push_front(int'(cand));
    if (hist.size() > 2) void'(hist.pop_back());
    n_deals++;
    check("done_dv",    32'(bus.deal_valid), 32'd1);
    check("done_busy",  32'(bus.busy), 32'd0);
    check("done_c0",    32'(bus.card0), 32'(exp_card[0]));
    check("done_c1",    32'(bus.card1), 32'(exp_card[1]));
    check("done_c2",    32'(bus.card2), 32'(exp_card[2]));
    check("done_c3",    32'(bus.card3), 32'(exp_card[3]));
    check("done_round", 32'(bus.round), 32'(m_round));
    $display("deal %0d idx=%0d rot=%0d retries=%0d cards=%0d,%0d,%0d,%0d round=%0d",
             n_deals, cand, rot, retry, bus.card0, bus.card1, bus.card2, bus.card3, bus.round);
  endtask

  initial begin
    bit prev_keep;
    bit keep;
    int r_before;
    rst           = 1'b1;
    bus.deal_req  = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed      = 8'h00;
    repeat (2) @(negedge clk);
    check_cleared("por");
    rst = 1'b0;

    // Idle: nothing should move.
    repeat (10) begin
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_dv",   32'(bus.deal_valid), 32'd0);
    end

    // Zero seed maps to A5: first pick is index 5, rot 2.
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed      = 8'h00;
    do_deal(1'b1, 1'b0, 1'b0, 1'b0);
    check("seed0_idx", 32'(bus.set_index), 32'd5);

    // Seed 8'h15 loaded on the request edge: index 5 with rot 1 gives 8,9,10,7.
    do_reset();
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed      = 8'h15;
    bus.deal_req  = 1'b1;
    do_deal(1'b0, 1'b0, 1'b0, 1'b0);
    check("dir_c0", 32'(bus.card0), 32'd8);
    check("dir_c1", 32'(bus.card1), 32'd9);
    check("dir_c2", 32'(bus.card2), 32'd10);
    check("dir_c3", 32'(bus.card3), 32'd7);

    // 50 deals from a random seed, mostly chained with deal_req held high.
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed      = 8'($urandom_range(1, 255));
    prev_keep = 1'b0;
    for (int i = 0; i < 50; i++) begin
      keep = (i == 49) ? 1'b0 : (($urandom % 4) != 0);
      do_deal(!prev_keep, keep, 1'b0, 1'b0);
      prev_keep = keep;
    end
    $display("forced accepts so far: %0d", forced);

    // deal_req pulsed during FETCH is ignored: one pulse, round +1.
    r_before = m_round;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    do_deal(1'b1, 1'b0, 1'b1, 1'b0);
    check("poke_round", 32'(bus.round), 32'(r_before + 1));
    repeat (4) begin
      @(negedge clk);
      check("poke_dv",   32'(bus.deal_valid), 32'd0);
      check("poke_busy", 32'(bus.busy), 32'd0);
    end

    // Reset in LATCH clears everything; the following deal acts as the first.
    do_deal(1'b1, 1'b0, 1'b0, 1'b1);
    do_deal(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_abort_idx", 32'(bus.set_index), 32'd5);
    check("post_abort_round", 32'(bus.round), 32'd1);

    // 256 chained deals from reset: round saturates at 255, deal 256 still pulses.
    do_reset();
    for (int i = 0; i < 256; i++) do_deal(i == 0, i != 255, 1'b0, 1'b0);
    check("sat_round", 32'(bus.round), 32'd255);
    @(negedge clk);
    check("sat_dv_drop", 32'(bus.deal_valid), 32'd0);
    $display("forced accepts total: %0d", forced);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog in case the DUT stalls the bench's sequencing.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
